wb_sdram_arbiter: RTL and testbench

//   Two-master Wishbone arbiter in front of the SDRAM controller's single slave port.

---
 rtl/wb_sdram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// rtl/wb_sdram_arbiter.sv - two-master (CPU/DMA) round-robin Wishbone arbiter for the SDRAM slave port
// Optional ARB_TIMEOUT_EN adds a slave-ack watchdog that aborts with 32'hDEAD_BEEF.
module wb_sdram_arbiter #(
    parameter logic [7:0] ADDR_BASE = 8'h38,
    parameter int         MAX_HOLD  = 4,
    parameter int         TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic        cpu_ack_o,
    output logic [31:0] cpu_dat_o,
    input  logic        dma_cyc_i,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_sel_i,
    input  logic [31:0] dma_adr_i,
    input  logic [31:0] dma_dat_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam int              HW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [31:0]     ABORT_DAT = 32'hDEAD_BEEF;

    if (MAX_HOLD < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("wb_sdram_arbiter: MAX_HOLD must be >= 1 and TIMEOUT in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_G_CPU = 2'd1,
        ST_G_DMA = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_dma;
    logic [HW-1:0]   r_hold;

    logic w_cpu_req;
    logic w_dma_req;
    logic w_g_cpu;
    logic w_g_dma;
    logic w_own_cyc;
    logic w_own_req;
    logic w_other_req;
    logic w_timeout;

    assign w_cpu_req = cpu_cyc_i & cpu_stb_i & (cpu_adr_i[31:24] == ADDR_BASE);
    assign w_dma_req = dma_cyc_i & dma_stb_i;
    assign w_g_cpu   = (r_state == ST_G_CPU);
    assign w_g_dma   = (r_state == ST_G_DMA);

    // Per-owner view of the granted master so the FSM logic is written once.
    assign w_own_cyc   = w_g_dma ? dma_cyc_i : cpu_cyc_i;
    assign w_own_req   = w_g_dma ? w_dma_req : w_cpu_req;
    assign w_other_req = w_g_dma ? w_cpu_req : w_dma_req;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
    logic [7:0] r_wait;
    assign w_timeout = (w_g_cpu | w_g_dma) & (r_wait == TO_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        if (w_g_cpu) begin
            s_cyc_o = cpu_cyc_i & ~w_timeout;
            s_stb_o = cpu_stb_i & ~w_timeout;
            s_we_o  = cpu_we_i;
            s_sel_o = cpu_sel_i;
            s_adr_o = cpu_adr_i;
            s_dat_o = cpu_dat_i;
        end else if (w_g_dma) begin
            s_cyc_o = dma_cyc_i & ~w_timeout;
            s_stb_o = dma_stb_i & ~w_timeout;
            s_we_o  = dma_we_i;
            s_sel_o = dma_sel_i;
            s_adr_o = dma_adr_i;
            s_dat_o = dma_dat_i;
        end
    end

    // An ack is only forwarded while the granted master still holds cyc.
    assign cpu_ack_o = w_g_cpu & (w_timeout | (s_ack_i & cpu_cyc_i));
    assign dma_ack_o = w_g_dma & (w_timeout | (s_ack_i & dma_cyc_i));
    assign cpu_dat_o = w_g_cpu ? (w_timeout ? ABORT_DAT : s_dat_i) : 32'h0;
    assign dma_dat_o = w_g_dma ? (w_timeout ? ABORT_DAT : s_dat_i) : 32'h0;
    assign grant_o   = {w_g_dma, w_g_cpu};
    assign timeout_o = w_timeout;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_last_dma <= 1'b1;
            r_hold     <= '0;
`ifdef ARB_TIMEOUT_EN
            r_wait     <= 8'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hold <= '0;
`ifdef ARB_TIMEOUT_EN
                    r_wait <= 8'h0;
`endif
                    if (w_cpu_req && w_dma_req) begin
                        r_state <= r_last_dma ? ST_G_CPU : ST_G_DMA;
                    end else if (w_cpu_req) begin
                        r_state <= ST_G_CPU;
                    end else if (w_dma_req) begin
                        r_state <= ST_G_DMA;
                    end
                end
                ST_G_CPU, ST_G_DMA: begin
                    if (!w_own_cyc || w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_last_dma <= w_g_dma;
                        r_hold     <= '0;
                    end else if (s_ack_i) begin
`ifdef ARB_TIMEOUT_EN
                        r_wait <= 8'h0;
`endif
                        // Keep the bus only while fairness allows another beat.
                        if (w_own_req && (!w_other_req || (r_hold < HOLD_LAST))) begin
                            if (r_hold < HOLD_MAX) begin
                                r_hold <= r_hold + HOLD_ONE;
                            end
                        end else begin
                            r_state    <= ST_IDLE;
                            r_last_dma <= w_g_dma;
                            r_hold     <= '0;
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        r_wait <= r_wait + 8'h1;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb/tb_wb_sdram_arbiter.sv - directed self-checking bench for wb_sdram_arbiter (MAX_HOLD=4, TIMEOUT=8)
module tb_wb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cyc, cpu_stb, cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_adr, cpu_dat;
    logic        cpu_ack;
    logic [31:0] cpu_rdat;
    logic        dma_cyc, dma_stb, dma_we;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_dat;
    logic        dma_ack;
    logic [31:0] dma_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  grant;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_sdram_arbiter #(.ADDR_BASE(8'h38), .MAX_HOLD(4), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
        .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_rdat),
        .dma_cyc_i(dma_cyc), .dma_stb_i(dma_stb), .dma_we_i(dma_we), .dma_sel_i(dma_sel),
        .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_ack_o(dma_ack), .dma_dat_o(dma_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .grant_o(grant), .timeout_o(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic [31:0] adr);
        cpu_cyc = req; cpu_stb = req; cpu_we = 1'b0; cpu_sel = 4'hF;
        cpu_adr = adr; cpu_dat = 32'h1111_0000;
    endtask

    task automatic dma_drive(input logic req, input logic [31:0] adr);
        dma_cyc = req; dma_stb = req; dma_we = 1'b1; dma_sel = 4'h3;
        dma_adr = adr; dma_dat = 32'h2222_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_drive(1'b0, 32'h0);
        dma_drive(1'b0, 32'h0);
        s_ack = 1'b0;
        s_rdat = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_seq [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [1:0] seq [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        rst = 1'b1;
        settle();
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_s_cyc", {31'h0, s_cyc}, 32'h0);
        check("rst_acks", {30'h0, cpu_ack, dma_ack}, 32'h0);
        check("rst_timeout", {31'h0, timeout}, 32'h0);
        rst = 1'b0;

        // 1: single CPU read, ack three cycles after strobe
        do_reset();
        cpu_drive(1'b1, 32'h3800_0010);
        settle();
        check("t1_grant_c0", {30'h0, grant}, 32'h0);
        check("t1_s_cyc_c0", {31'h0, s_cyc}, 32'h0);
        tick();
        check("t1_grant_c1", {30'h0, grant}, 32'h1);
        check("t1_s_cyc_c1", {31'h0, s_cyc}, 32'h1);
        check("t1_s_adr", s_adr, 32'h3800_0010);
        check("t1_s_sel", {28'h0, s_sel}, 32'hF);
        check("t1_ack_c1", {31'h0, cpu_ack}, 32'h0);
        tick();
        check("t1_ack_c2", {31'h0, cpu_ack}, 32'h0);
        tick();
        s_ack = 1'b1;
        s_rdat = 32'hCAFE_0010;
        settle();
        check("t1_cpu_ack", {31'h0, cpu_ack}, 32'h1);
        check("t1_cpu_dat", cpu_rdat, 32'hCAFE_0010);
        check("t1_dma_ack", {31'h0, dma_ack}, 32'h0);
        check("t1_dma_dat", dma_rdat, 32'h0);
        tick();
        s_ack = 1'b0;
        cpu_drive(1'b0, 32'h0);
        tick();
        check("t1_idle_after", {30'h0, grant}, 32'h0);

        // 2: simultaneous requests alternate C,D,C,D
        do_reset();
        cpu_drive(1'b1, 32'h3800_0100);
        dma_drive(1'b1, 32'h0000_2000);
        for (int i = 0; i < 4; i++) begin
            int w;
            w = 0;
            while (grant == 2'b00 && w < 8) begin
                tick();
                w++;
            end
            check("t2_order", {30'h0, grant}, {30'h0, exp_order[i]});
            s_ack = 1'b1;
            settle();
            check("t2_acks", {30'h0, dma_ack, cpu_ack}, {30'h0, exp_order[i]});
            tick();
            s_ack = 1'b0;
            if (exp_order[i] == 2'b01) cpu_drive(1'b0, 32'h3800_0100);
            else dma_drive(1'b0, 32'h0000_2000);
            tick();
            if (exp_order[i] == 2'b01) cpu_drive(1'b1, 32'h3800_0100);
            else dma_drive(1'b1, 32'h0000_2000);
        end

        // 3: DMA burst of 10 vs CPU single access, hold limit 4
        do_reset();
        dma_drive(1'b1, 32'h0000_4000);
        tick();
        begin
            int cpu_acks;
            int dma_acks;
            cpu_acks = 0;
            dma_acks = 0;
            seq.delete();
            for (int c = 0; c < 60 && seq.size() < 11; c++) begin
                dma_drive(dma_acks < 10, 32'h0000_4000 + 32'(dma_acks));
                cpu_drive(cpu_acks < 1, 32'h3800_0200);
                settle();
                s_ack = s_cyc & s_stb;
                settle();
                if (cpu_ack) begin seq.push_back(2'b01); cpu_acks++; end
                if (dma_ack) begin seq.push_back(2'b10); dma_acks++; end
                tick();
            end
            s_ack = 1'b0;
            check("t3_ack_count", seq.size(), 32'd11);
            for (int i = 0; i < 11 && i < seq.size(); i++)
                check("t3_ack_owner", {30'h0, seq[i]}, {30'h0, exp_seq[i]});
        end
        cpu_drive(1'b0, 32'h0);
        dma_drive(1'b0, 32'h0);

        // 4: CPU outside the SDRAM window is ignored
        do_reset();
        cpu_drive(1'b1, 32'h3000_0000);
        s_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("t4_grant", {30'h0, grant}, 32'h0);
            check("t4_s_cyc", {31'h0, s_cyc}, 32'h0);
            check("t4_cpu_ack", {31'h0, cpu_ack}, 32'h0);
            tick();
        end
        s_ack = 1'b0;
        cpu_drive(1'b0, 32'h0);

        // 5: asynchronous reset in the middle of a DMA transaction
        do_reset();
        dma_drive(1'b1, 32'h0000_0040);
        tick();
        check("t5_grant", {30'h0, grant}, 32'h2);
        check("t5_s_cyc", {31'h0, s_cyc}, 32'h1);
        check("t5_s_we", {31'h0, s_we}, 32'h1);
        #2;
        s_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("t5_rst_s_cyc", {31'h0, s_cyc}, 32'h0);
        check("t5_rst_grant", {30'h0, grant}, 32'h0);
        check("t5_rst_ack", {31'h0, dma_ack}, 32'h0);
        #2;
        rst = 1'b0;
        s_ack = 1'b0;
        dma_drive(1'b0, 32'h0);
        tick();
        check("t5_post_idle1", {30'h0, grant}, 32'h0);
        tick();
        check("t5_post_idle2", {30'h0, grant}, 32'h0);
        dma_drive(1'b1, 32'h0000_0080);
        tick();
        check("t5_regrant", {30'h0, grant}, 32'h2);
        dma_drive(1'b0, 32'h0);

        // 6: slave never acks
        do_reset();
        cpu_drive(1'b1, 32'h3800_0020);
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int g = 1; g <= 9; g++) begin
            settle();
            check("t6_ack", {31'h0, cpu_ack}, {31'h0, g == 9});
            check("t6_timeout", {31'h0, timeout}, {31'h0, g == 9});
            if (g == 9) begin
                check("t6_dat", cpu_rdat, 32'hDEAD_BEEF);
                check("t6_s_cyc", {31'h0, s_cyc}, 32'h0);
            end
            tick();
        end
        check("t6_idle", {30'h0, grant}, 32'h0);
        cpu_drive(1'b0, 32'h0);
`else
        for (int g = 1; g <= 20; g++) begin
            settle();
            check("t6_no_ack", {31'h0, cpu_ack}, 32'h0);
            check("t6_no_timeout", {31'h0, timeout}, 32'h0);
            tick();
        end
        check("t6_still_granted", {30'h0, grant}, 32'h1);
        cpu_drive(1'b0, 32'h0);
        tick();
        tick();
        check("t6_idle", {30'h0, grant}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
